// File: rtl/oneshot_readout.sv
// oneshot_readout: reads words 0..last_addr from the one-shot ADC snapshot
// memory and serialises each word into a lane-per-beat valid/ready stream.
// Lane k of a word is mem_rdata[k*LANE_W +: LANE_W]; out_last marks the
// final lane of the final word.
module oneshot_readout #(
    parameter  int N_LANES    = 18,
    parameter  int LANE_W     = 8,
    parameter  int ADDR_W     = 10,
    localparam int LANE_IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [ADDR_W-1:0]           last_addr,
    output logic                        mem_en,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [N_LANES*LANE_W-1:0]   mem_rdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANE_W-1:0]           out_data,
    output logic [LANE_IDX_W-1:0]       out_lane,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(N_LANES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        LOAD,
        SEND
    } state_t;

    state_t                      state_q, state_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [ADDR_W-1:0]           lim_q, lim_d;
    logic [LANE_IDX_W-1:0]       lane_q, lane_d;
    logic [N_LANES*LANE_W-1:0]   shift_q, shift_d;
    logic [LANE_W-1:0]           out_data_q, out_data_d;
    logic                        mem_en_q, mem_en_d;
    logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
    logic                        out_valid_q, out_valid_d;
    logic                        out_last_q, out_last_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        consume;

    // Next-state and next-output logic; every output is derived from the next state so it is registered.
    always_comb begin
        // NOTE: every _d gets a default before any branch so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        addr_d     = addr_q;
        lim_d      = lim_q;
        lane_d     = lane_q;
        shift_d    = shift_q;
        out_data_d = out_data_q;
        done_d     = done_q;
        consume    = out_valid_q && out_ready;

        if (abort) begin
            // Abort overrides start and any consumed beat; the word in flight is dropped.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        lim_d   = last_addr;
                        addr_d  = '0;
                        done_d  = 1'b0;
                        state_d = REQ;
                    end
                end
                REQ: begin
                    state_d = LOAD;
                end
                LOAD: begin
                    // Lane 0 goes straight to the output; the rest wait in shift_q, lowest lane at the bottom.
                    out_data_d = mem_rdata[LANE_W-1:0];
                    shift_d    = mem_rdata >> LANE_W;
                    lane_d     = '0;
                    state_d    = SEND;
                end
                SEND: begin
                    if (consume) begin
                        if (lane_q != LAST_LANE) begin
                            lane_d     = lane_q + 1'b1;
                            out_data_d = shift_q[LANE_W-1:0];
                            shift_d    = shift_q >> LANE_W;
                        end else if (addr_q == lim_q) begin
                            // Compare before incrementing so a full-memory read never wraps addr_q.
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = REQ;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        mem_en_d    = (state_d == REQ);
        mem_addr_d  = (state_d == REQ) ? addr_d : mem_addr_q;
        out_valid_d = (state_d == SEND);
        out_last_d  = (state_d == SEND) && (lane_d == LAST_LANE) && (addr_d == lim_d);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers with synchronous reset that overrides all inputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values computed above.
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            lim_q       <= '0;
            lane_q      <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            lim_q       <= lim_d;
            lane_q      <= lane_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_lane  = lane_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_oneshot_readout.sv
// Testbench for oneshot_readout: a memory model answers mem_en one cycle
// later (random data otherwise); a scoreboard queue holds the expected beats
// and a negedge monitor pops and compares every consumed beat and checks
// that a stalled beat is held stable.
module tb_oneshot_readout;

    localparam int N_LANES    = 18;
    localparam int LANE_W     = 8;
    localparam int ADDR_W     = 10;
    localparam int LANE_IDX_W = $clog2(N_LANES);

    typedef struct packed {
        logic [LANE_W-1:0]     data;
        logic [LANE_IDX_W-1:0] lane;
        logic                  last;
    } beat_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic                      abort;
    logic [ADDR_W-1:0]         last_addr;
    logic                      mem_en;
    logic [ADDR_W-1:0]         mem_addr;
    logic [N_LANES*LANE_W-1:0] mem_rdata;
    logic [N_LANES*LANE_W-1:0] junk;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANE_W-1:0]         out_data;
    logic [LANE_IDX_W-1:0]     out_lane;
    logic                      out_last;
    logic                      busy;
    logic                      done;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    oneshot_readout #(
        .N_LANES(N_LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .last_addr(last_addr),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane(out_lane), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Word a holds lane k = a*N_LANES + k (truncated to LANE_W bits).
    function automatic logic [N_LANES*LANE_W-1:0] word_of(input int a);
        logic [N_LANES*LANE_W-1:0] w;
        for (int k = 0; k < N_LANES; k++) w[k*LANE_W +: LANE_W] = LANE_W'(a * N_LANES + k);
        return w;
    endfunction

    // Memory model: data valid one cycle after mem_en, garbage otherwise.
    always @(posedge clk) begin
        for (int k = 0; k < N_LANES; k++) junk[k*LANE_W +: LANE_W] = LANE_W'($urandom);
        if (mem_en) mem_rdata <= word_of(int'(mem_addr));
        else        mem_rdata <= junk;
    end

    // Scoreboard monitor: compare consumed beats, and hold-stability of stalled beats.
    beat_t prev_beat;
    logic  prev_stall = 1'b0;
    always @(negedge clk) begin
        beat_t got, want;
        got = {out_data, out_lane, out_last};
        if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || got !== prev_beat) begin
                failures++;
                $display("FAIL stall_hold: valid=%b beat=%h, required valid=1 beat=%h", out_valid, got, prev_beat);
            end
        end
        if (rst === 1'b0 && abort === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat_extra: got data=%0d lane=%0d last=%b, required no beat", out_data, out_lane, out_last);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL beat: got data=%0d lane=%0d last=%b, required data=%0d lane=%0d last=%b",
                             got.data, got.lane, got.last, want.data, want.lane, want.last);
                end
            end
        end
        prev_stall = (rst === 1'b0) && (abort === 1'b0) && (out_valid === 1'b1) && (out_ready === 1'b0);
        prev_beat  = got;
    end

    task automatic push_expected(input int la);
        beat_t b;
        for (int a = 0; a <= la; a++) begin
            for (int k = 0; k < N_LANES; k++) begin
                b.data = LANE_W'(a * N_LANES + k);
                b.lane = LANE_IDX_W'(k);
                b.last = (a == la) && (k == N_LANES - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // Start cycle is cycle 0; returns one cycle into the readout (cycle 1 inputs being driven).
    task automatic pulse_start(input logic [ADDR_W-1:0] la);
        @(posedge clk); #1;
        last_addr = la;
        start     = 1'b1;
        abort     = 1'b0;
        push_expected(int'(la));
        @(posedge clk); #1;
        start     = 1'b0;
        last_addr = ADDR_W'($urandom);
    endtask

    // Runs the readout until busy drops (n_end = that cycle) or max_cycles expire (n_end = -1).
    task automatic drain(input bit rnd, input int max_cycles, input int abort_at, input int restart_at,
                         output int n_end, output int first_valid, output int bubbles,
                         output int mem_en_cnt, output int beats, output int abort_cycle,
                         output logic done_at_start);
        int n = 0;
        bit fired = 1'b0;
        bit restarted = 1'b0;
        n_end = -1; first_valid = -1; bubbles = 0; mem_en_cnt = 0; beats = 0;
        abort_cycle = -1; done_at_start = 1'bx;
        out_ready = rnd ? 1'($urandom) : 1'b1;
        while (n < max_cycles) begin
            @(negedge clk);
            n++;
            if (n == 1) done_at_start = done;
            if (mem_en) mem_en_cnt++;
            if (out_valid && first_valid < 0) first_valid = n;
            if (!out_valid && busy && beats > 0) bubbles++;
            if (out_valid && out_ready && !abort) beats++;
            if (!busy) begin
                n_end = n;
                break;
            end
            @(posedge clk); #1;
            abort = 1'b0;
            start = 1'b0;
            out_ready = rnd ? 1'($urandom) : 1'b1;
            if (abort_at >= 0 && !fired && beats == abort_at) begin
                abort = 1'b1; fired = 1'b1; abort_cycle = n + 1;
            end
            if (restart_at >= 0 && !restarted && beats == restart_at) begin
                start = 1'b1; last_addr = 10'd3; restarted = 1'b1;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            start = 1'($urandom); abort = 1'($urandom); out_ready = 1'($urandom);
            last_addr = ADDR_W'($urandom);
            @(negedge clk);
            checks++;
            if ({mem_en, mem_addr, out_valid, out_data, out_lane, out_last, busy, done} !== '0) begin
                failures++;
                $display("FAIL reset_outputs: got en=%b addr=%0d valid=%b data=%0d lane=%0d last=%b busy=%b done=%b, required all 0",
                         mem_en, mem_addr, out_valid, out_data, out_lane, out_last, busy, done);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1; last_addr = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_sequential;
        int n_end, fv, bub, en_cnt, beats, ac;
        logic d0;
        pulse_start(10'd3);
        drain(1'b0, 300, -1, -1, n_end, fv, bub, en_cnt, beats, ac, d0);
        checks++; if (n_end !== 81) begin failures++; $display("FAIL seq_end_cycle: got %0d, required 81", n_end); end
        checks++; if (fv !== 3) begin failures++; $display("FAIL seq_first_beat: got %0d, required 3", fv); end
        checks++; if (bub !== 6) begin failures++; $display("FAIL seq_word_gaps: got %0d, required 6", bub); end
        checks++; if (beats !== 72) begin failures++; $display("FAIL seq_beats: got %0d, required 72", beats); end
        checks++; if (en_cnt !== 4) begin failures++; $display("FAIL seq_mem_en: got %0d, required 4", en_cnt); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL seq_done: got done=%b busy=%b, required 1 0", done, busy); end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL seq_left: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_random_ready;
        int n_end, fv, bub, en_cnt, beats, ac;
        logic d0;
        pulse_start(10'd3);
        drain(1'b1, 1000, -1, -1, n_end, fv, bub, en_cnt, beats, ac, d0);
        checks++; if (n_end < 0) begin failures++; $display("FAIL rnd_timeout: got %0d, required >0", n_end); end
        checks++; if (d0 !== 1'b0) begin failures++; $display("FAIL rnd_done_clear: got %b, required 0", d0); end
        checks++; if (fv !== 3) begin failures++; $display("FAIL rnd_first_beat: got %0d, required 3", fv); end
        checks++; if (bub !== 6) begin failures++; $display("FAIL rnd_word_gaps: got %0d, required 6", bub); end
        checks++; if (beats !== 72) begin failures++; $display("FAIL rnd_beats: got %0d, required 72", beats); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL rnd_done: got %b, required 1", done); end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL rnd_left: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_single_word;
        int n_end, fv, bub, en_cnt, beats, ac;
        logic d0;
        pulse_start(10'd0);
        drain(1'b0, 300, -1, 5, n_end, fv, bub, en_cnt, beats, ac, d0);
        checks++; if (n_end !== 21) begin failures++; $display("FAIL one_end_cycle: got %0d, required 21", n_end); end
        checks++; if (beats !== 18) begin failures++; $display("FAIL one_beats: got %0d, required 18", beats); end
        checks++; if (en_cnt !== 1) begin failures++; $display("FAIL one_mem_en: got %0d, required 1", en_cnt); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL one_done: got %b, required 1", done); end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL one_left: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_abort;
        int n_end, fv, bub, en_cnt, beats, ac;
        logic d0;
        pulse_start(10'd3);
        drain(1'b0, 300, 20, -1, n_end, fv, bub, en_cnt, beats, ac, d0);
        checks++; if (n_end !== ac + 1 || ac < 0) begin failures++; $display("FAIL abort_latency: got end=%0d abort=%0d, required end=abort+1", n_end, ac); end
        checks++; if (out_valid !== 1'b0 || mem_en !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL abort_outputs: got valid=%b en=%b done=%b, required 0 0 0", out_valid, mem_en, done); end
        checks++; if (exp_q.size() !== 52) begin failures++; $display("FAIL abort_beats_left: got %0d, required 52", exp_q.size()); end
        exp_q.delete();
        // start and abort together while idle: abort wins.
        @(posedge clk); #1; start = 1'b1; abort = 1'b1; last_addr = 10'd3;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || mem_en !== 1'b0) begin failures++; $display("FAIL abort_vs_start: got busy=%b en=%b, required 0 0", busy, mem_en); end
        pulse_start(10'd3);
        drain(1'b0, 300, -1, -1, n_end, fv, bub, en_cnt, beats, ac, d0);
        checks++; if (n_end !== 81 || beats !== 72) begin failures++; $display("FAIL abort_replay: got end=%0d beats=%0d, required 81 72", n_end, beats); end
        checks++; if (done !== 1'b1 || exp_q.size() !== 0) begin failures++; $display("FAIL abort_replay_done: got done=%b left=%0d, required 1 0", done, exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        pulse_start(10'd3);
        out_ready = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_addr, out_valid, out_data, out_lane, out_last, busy, done} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got en=%b addr=%0d valid=%b data=%0d lane=%0d last=%b busy=%b done=%b, required all 0",
                     mem_en, mem_addr, out_valid, out_data, out_lane, out_last, busy, done);
        end
        checks++; if (exp_q.size() !== 64) begin failures++; $display("FAIL rst_mid_beats_left: got %0d, required 64", exp_q.size()); end
        exp_q.delete();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (mem_en || out_valid || busy) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL rst_mid_quiet: got %0d active cycles, required 0", bad); end
    endtask

    task automatic test_full_memory;
        int n_end, fv, bub, en_cnt, beats, ac;
        logic d0;
        pulse_start(10'd1023);
        drain(1'b0, 21000, -1, -1, n_end, fv, bub, en_cnt, beats, ac, d0);
        checks++; if (n_end !== 20481) begin failures++; $display("FAIL full_end_cycle: got %0d, required 20481", n_end); end
        checks++; if (beats !== 18432) begin failures++; $display("FAIL full_beats: got %0d, required 18432", beats); end
        checks++; if (en_cnt !== 1024) begin failures++; $display("FAIL full_mem_en: got %0d, required 1024", en_cnt); end
        checks++; if (done !== 1'b1 || exp_q.size() !== 0) begin failures++; $display("FAIL full_done: got done=%b left=%0d, required 1 0", done, exp_q.size()); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_random_ready();
        test_single_word();
        test_abort();
        test_reset_mid();
        test_full_memory();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
